// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer of the dual-clock FIFO. Pops DSIZE-bit words, packs
// PACK of them into one wide beat and presents beats on a valid/ready stream.
// A flush pulse closes a partially filled beat with a lane-keep mask and a
// last marker. Pops are paced so that the FIFO's registered data, lagging
// empty flag and lagging count can never cause an underflow or a lost word.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   fifo_empty,
    input  logic [4:0]             fifo_count,
    output logic                   fifo_rd_en,
    input  logic [DSIZE-1:0]       fifo_rd_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DSIZE*PACK-1:0]  out_data,
    output logic [PACK-1:0]        out_keep,
    output logic                   out_last
);

    localparam int LW = $clog2(PACK + 1);
    localparam int CW = LW + 1;

    // pack register and bookkeeping
    logic [DSIZE*PACK-1:0] r_pack;
    logic [LW-1:0]         r_lanes;
    logic                  r_inflight;
    logic                  r_flush_pend;

    // output register
    logic                  r_out_valid;
    logic [DSIZE*PACK-1:0] r_out_data;
    logic [PACK-1:0]       r_out_keep;
    logic                  r_out_last;

    logic                  w_out_free;
    logic                  w_full;
    logic                  w_xfer;
    logic                  w_flush_done;
    logic                  w_emit_part;
    logic                  w_credit;
    logic                  w_lag_ok;
    logic                  w_rd_en;
    logic [LW-1:0]         w_cap_idx;
    logic [LW-1:0]         w_lanes_nxt;
    logic [PACK-1:0]       w_mask;
    logic [DSIZE*PACK-1:0] w_beat;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_full       = (r_lanes == LW'(PACK));
    assign w_xfer       = w_full && w_out_free;

    // A flush waits for the in-flight word to land and for a free output
    // register; a full pack register is always shipped first as a normal beat.
    assign w_flush_done = r_flush_pend && !r_inflight && w_out_free && !w_full;
    assign w_emit_part  = w_flush_done && (r_lanes != '0);

    // Credit counts the word already in flight so it always has a lane to land
    // in; a same-cycle transfer frees the whole register.
    assign w_credit     = (({1'b0, r_lanes} + CW'(r_inflight)) < CW'(PACK)) || w_xfer;

    // The count lags one pop behind, so back-to-back pops need headroom of 3.
    assign w_lag_ok     = !r_inflight || (fifo_count >= 5'd3);

    assign w_rd_en      = !rd_rst && !fifo_empty && !r_flush_pend && w_credit && w_lag_ok;

    // A capture that coincides with a transfer starts the next beat at lane 0.
    assign w_cap_idx    = w_xfer ? '0 : r_lanes;

    // Lane-count update: transfer and flush close the beat, capture appends.
    always_comb begin
        w_lanes_nxt = r_lanes;
        if (w_xfer) begin
            w_lanes_nxt = r_inflight ? LW'(1) : '0;
        end else if (w_flush_done) begin
            w_lanes_nxt = '0;
        end else if (r_inflight) begin
            w_lanes_nxt = r_lanes + LW'(1);
        end
    end

    // Beat image: only filled lanes are passed through, unused lanes read 0.
    always_comb begin
        w_mask = '0;
        w_beat = '0;
        for (int i = 0; i < PACK; i++) begin
            if (LW'(i) < r_lanes) begin
                w_mask[i]                  = 1'b1;
                w_beat[i*DSIZE +: DSIZE]   = r_pack[i*DSIZE +: DSIZE];
            end
        end
    end

    // Capture the registered FIFO read data one cycle after its pop.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_pack <= '0;
        end else if (r_inflight) begin
            for (int i = 0; i < PACK; i++) begin
                if (w_cap_idx == LW'(i)) begin
                    r_pack[i*DSIZE +: DSIZE] <= fifo_rd_data;
                end
            end
        end
    end

    // Lane count, in-flight marker and sticky flush request.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_lanes      <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_lanes      <= w_lanes_nxt;
            r_inflight   <= w_rd_en;
            r_flush_pend <= (r_flush_pend && !w_flush_done) || flush;
        end
    end

    // Output register: loads full or flushed beats, holds until handshake.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer || w_emit_part) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat;
            r_out_keep  <= w_mask;
            r_out_last  <= w_emit_part;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_keep   = r_out_keep;
    assign out_last   = r_out_last;

endmodule
